// File: rtl/random_checker.sv
// Receive-side checker for the 5-bit xor-recurrence random generator.
// Seeds a predictor from the stream, locks after a run of correct predictions, then flywheels and counts mismatches.
module random_checker #(
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       in_data,
    input  logic             clear_counts,
    output logic             locked,
    output logic             mismatch,
    output logic             sync_lost,
    output logic [4:0]       expected,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_COUNT);
    localparam logic [3:0]       UNLOCK_TGT = 4'(UNLOCK_ERRS);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    // The terms chain: n2 uses the new n4, n1 the new n3, n0 the new n2.
    function automatic logic [4:0] next_rand(input logic [4:0] r);
        logic n4, n3, n2, n1, n0;
        n4 = r[4] ^ r[1];
        n3 = r[3] ^ r[0];
        n2 = r[2] ^ n4;
        n1 = r[1] ^ n3;
        n0 = r[0] ^ n2;
        return {n4, n3, n2, n1, n0};
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       expected_q, expected_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       bad_q, bad_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             mismatch_q, mismatch_d;
    logic             sync_lost_q, sync_lost_d;

    logic [4:0] seed_pred;
    logic [4:0] fly_pred;
    logic [3:0] run_inc;
    logic [3:0] bad_inc;
    logic       hit;
    logic       zero_in;

    assign seed_pred = next_rand(in_data);
    assign fly_pred  = next_rand(expected_q);
    assign run_inc   = run_q + 4'd1;
    assign bad_inc   = bad_q + 4'd1;
    assign hit       = (in_data == expected_q);
    assign zero_in   = (in_data == 5'h00);

    // NOTE: every variable gets its hold value first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        run_d       = run_q;
        bad_d       = bad_q;
        err_d       = err_q;
        mismatch_d  = 1'b0;
        sync_lost_d = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (!zero_in) begin
                        expected_d = seed_pred;
                        run_d      = 4'd0;
                        state_d    = CONFIRM;
                    end
                end

                CONFIRM: begin
                    if (hit) begin
                        run_d      = run_inc;
                        expected_d = seed_pred;
                        if (run_inc == LOCK_TGT) begin
                            state_d = LOCKED;
                            bad_d   = 4'd0;
                        end
                    end else if (!zero_in) begin
                        expected_d = seed_pred;
                        run_d      = 4'd0;
                    end else begin
                        state_d    = HUNT;
                        expected_d = 5'h00;
                        run_d      = 4'd0;
                    end
                end

                LOCKED: begin
                    // Flywheel: once locked the data never reseeds the predictor.
                    expected_d = fly_pred;
                    if (hit) begin
                        bad_d = 4'd0;
                    end else begin
                        mismatch_d = 1'b1;
                        bad_d      = bad_inc;
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (bad_inc == UNLOCK_TGT) begin
                            state_d     = HUNT;
                            sync_lost_d = 1'b1;
                            expected_d  = 5'h00;
                            run_d       = 4'd0;
                            bad_d       = 4'd0;
                        end
                    end
                end

                default: begin
                    state_d    = HUNT;
                    expected_d = 5'h00;
                    run_d      = 4'd0;
                    bad_d      = 4'd0;
                end
            endcase
        end

        if (clear_counts) begin
            err_d = '0;
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            expected_q  <= 5'h00;
            run_q       <= 4'd0;
            bad_q       <= 4'd0;
            err_q       <= '0;
            mismatch_q  <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            bad_q       <= bad_d;
            err_q       <= err_d;
            mismatch_q  <= mismatch_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign mismatch  = mismatch_q;
    assign sync_lost = sync_lost_q;
    assign expected  = expected_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_random_checker.sv
// Directed self-checking bench for random_checker; expected values hand-derived from the recurrence.
// A second instance with a 2-bit counter and a high unlock threshold covers saturation and clear collision.
module tb_random_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_data;
    logic        clear_counts;

    logic        locked, mismatch, sync_lost;
    logic [4:0]  expected;
    logic [15:0] err_count;

    logic        locked2, mismatch2, sync_lost2;
    logic [4:0]  expected2;
    logic [1:0]  err_count2;

    int checks = 0;
    int errors = 0;

    random_checker dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clear_counts (clear_counts),
        .locked       (locked),
        .mismatch     (mismatch),
        .sync_lost    (sync_lost),
        .expected     (expected),
        .err_count    (err_count)
    );

    random_checker #(
        .LOCK_COUNT  (4),
        .UNLOCK_ERRS (15),
        .ERR_W       (2)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clear_counts (clear_counts),
        .locked       (locked2),
        .mismatch     (mismatch2),
        .sync_lost    (sync_lost2),
        .expected     (expected2),
        .err_count    (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic el, input logic em, input logic es,
                             input logic [4:0] ee, input logic [15:0] eerr);
        check({tag, ".locked"},    32'(locked),    32'(el));
        check({tag, ".mismatch"},  32'(mismatch),  32'(em));
        check({tag, ".sync_lost"}, 32'(sync_lost), 32'(es));
        check({tag, ".expected"},  32'(expected),  32'(ee));
        check({tag, ".err_count"}, 32'(err_count), 32'(eerr));
    endtask

    task automatic check_dut2(input string tag, input logic el, input logic em, input logic es,
                              input logic [4:0] ee, input logic [1:0] eerr);
        check({tag, ".locked2"},    32'(locked2),    32'(el));
        check({tag, ".mismatch2"},  32'(mismatch2),  32'(em));
        check({tag, ".sync_lost2"}, 32'(sync_lost2), 32'(es));
        check({tag, ".expected2"},  32'(expected2),  32'(ee));
        check({tag, ".err_count2"}, 32'(err_count2), 32'(eerr));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic apply(input logic [4:0] d, input logic clr);
        @(negedge clk);
        in_valid     = 1'b1;
        in_data      = d;
        clear_counts = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid     = 1'b0;
            in_data      = 5'h1F;
            clear_counts = clr;
            @(posedge clk);
            #1;
        end
    endtask

    // Reset is held with valid data present to show it overrides the datapath.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        in_valid     = 1'b1;
        in_data      = 5'h1F;
        clear_counts = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset        = 1'b0;
        in_valid     = 1'b0;
        clear_counts = 1'b0;
    endtask

    // f(1F)=06, so 0C reseeds; then 0F,13,09,01 are four correct predictions and lock follows 01.
    task automatic lock_run(input int gap);
        logic [4:0] seq [6];
        logic [4:0] exp [6];
        logic       lk  [6];
        seq = '{5'h1F, 5'h0C, 5'h0F, 5'h13, 5'h09, 5'h01};
        exp = '{5'h06, 5'h0F, 5'h13, 5'h09, 5'h01, 5'h0B};
        lk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            apply(seq[i], 1'b0);
            check_dut($sformatf("lock_g%0d_s%0d", gap, i), lk[i], 1'b0, 1'b0, exp[i], 16'd0);
            if (gap > 0) begin
                idle(gap, 1'b0);
                check_dut($sformatf("gap_g%0d_s%0d", gap, i), lk[i], 1'b0, 1'b0, exp[i], 16'd0);
            end
        end
    endtask

    initial begin
        logic [4:0] rs_seq [9];
        logic [4:0] rs_exp [9];
        logic [1:0] sat    [5];

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 5'h00;
        clear_counts = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_dut("reset", 1'b0, 1'b0, 1'b0, 5'h00, 16'd0);
        check_dut2("reset", 1'b0, 1'b0, 1'b0, 5'h00, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back lock acquisition.
        lock_run(0);

        // Same stream with three idle cycles between samples; outputs must hold in the gaps.
        do_reset();
        check_dut("reset2", 1'b0, 1'b0, 1'b0, 5'h00, 16'd0);
        lock_run(3);

        // Single wrong sample while locked: flywheel keeps the prediction on track.
        apply(5'h1E, 1'b0);
        check_dut("single_err", 1'b1, 1'b1, 1'b0, 5'h16, 16'd1);
        apply(5'h16, 1'b0);
        check_dut("resume_1", 1'b1, 1'b0, 1'b0, 5'h07, 16'd1);
        apply(5'h07, 1'b0);
        check_dut("resume_2", 1'b1, 1'b0, 1'b0, 5'h19, 16'd1);
        idle(1, 1'b1);
        check_dut("clear_idle", 1'b1, 1'b0, 1'b0, 5'h19, 16'd0);

        // Three consecutive wrong samples drop lock with sync_lost on the third.
        apply(5'h00, 1'b0);
        check_dut("loss_1", 1'b1, 1'b1, 1'b0, 5'h14, 16'd1);
        apply(5'h00, 1'b0);
        check_dut("loss_2", 1'b1, 1'b1, 1'b0, 5'h10, 16'd2);
        apply(5'h00, 1'b0);
        check_dut("loss_3", 1'b0, 1'b1, 1'b1, 5'h00, 16'd3);
        idle(1, 1'b0);
        check_dut("loss_idle", 1'b0, 1'b0, 1'b0, 5'h00, 16'd3);
        apply(5'h05, 1'b0);
        check_dut("loss_reseed", 1'b0, 1'b0, 1'b0, 5'h0E, 16'd3);

        // Zero ignored in HUNT, repeated reseeds in CONFIRM, then run restarts from the last seed.
        do_reset();
        rs_seq = '{5'h00, 5'h1F, 5'h0C, 5'h05, 5'h0C, 5'h0F, 5'h13, 5'h09, 5'h01};
        rs_exp = '{5'h00, 5'h06, 5'h0F, 5'h0E, 5'h0F, 5'h13, 5'h09, 5'h01, 5'h0B};
        for (int i = 0; i < 9; i++) begin
            apply(rs_seq[i], 1'b0);
            check_dut($sformatf("reseed_s%0d", i), (i == 8), 1'b0, 1'b0, rs_exp[i], 16'd0);
        end

        // Saturation and clear collision on the narrow-counter instance.
        do_reset();
        lock_run(0);
        check_dut2("sat_locked", 1'b1, 1'b0, 1'b0, 5'h0B, 2'd0);
        sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            apply(5'h00, 1'b0);
            check({$sformatf("sat_s%0d", i), ".locked2"},    32'(locked2),    32'(1));
            check({$sformatf("sat_s%0d", i), ".mismatch2"},  32'(mismatch2),  32'(1));
            check({$sformatf("sat_s%0d", i), ".err_count2"}, 32'(err_count2), 32'(sat[i]));
        end
        apply(5'h00, 1'b1);
        check({"clr_collide", ".locked2"},    32'(locked2),    32'(1));
        check({"clr_collide", ".mismatch2"},  32'(mismatch2),  32'(1));
        check({"clr_collide", ".err_count2"}, 32'(err_count2), 32'(0));
        apply(5'h00, 1'b0);
        check({"post_clear", ".err_count2"}, 32'(err_count2), 32'(1));

        // Reset while locked, with valid data on the same edge.
        @(negedge clk);
        reset        = 1'b1;
        in_valid     = 1'b1;
        in_data      = 5'h00;
        clear_counts = 1'b0;
        @(posedge clk);
        #1;
        check_dut2("reset_locked", 1'b0, 1'b0, 1'b0, 5'h00, 2'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
